// File: rtl/fifo_rd_packer_pkg.sv
// Shared types for the FIFO read-side packer: FSM states and the lane index/fill-count type.
package fifo_rd_pkg;

  localparam int MAX_PACK = 16;

  typedef enum logic [1:0] {
    FILL,
    STALL,
    FLUSH
  } state_t;

  // Wide enough to hold a fill count of MAX_PACK, not just the highest lane index.
  typedef logic [$clog2(MAX_PACK + 1)-1:0] lane_idx_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed valid/ready output bus; master is the packer side.
interface fifo_rd_packer_if #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4
);
  localparam int CW = $clog2(PACK + 1);

  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic [WIDTH-1:0]      fifo_rdata;
  logic                  fifo_rd_en;
  logic                  flush;
  logic                  out_ready;
  logic                  out_valid;
  logic [WIDTH*PACK-1:0] out_data;
  logic [CW-1:0]         out_cnt;
  logic                  err;

  modport master (
    input  fifo_empty, fifo_underflow, fifo_rdata, flush, out_ready,
    output fifo_rd_en, out_valid, out_data, out_cnt, err
  );

  modport slave (
    output fifo_empty, fifo_underflow, fifo_rdata, flush, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_cnt, err
  );
endinterface

// File: rtl/fifo_lane_asm.sv
// Lane assembly register: writes each captured word at the current fill index, clears as a unit.
module fifo_lane_asm
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PACK  = 4
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       clr,
  output lane_idx_t                  lanes,
  output logic [PACK-1:0][WIDTH-1:0] assembled
);

  logic [PACK-1:0][WIDTH-1:0] lane_q;

  // assembled includes this cycle's write so a completing word can be loaded on the same edge.
  always_comb begin
    // NOTE: default assignment first so every path drives assembled and no latch is inferred.
    assembled = lane_q;
    for (int i = 0; i < PACK; i++) begin
      if (wr && (lanes == lane_idx_t'(i))) assembled[i] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    // NOTE: the lane array is reset (unlike a plain RAM) because a flushed word relies on
    //       unused lanes reading as zero.
    if (!res) begin
      lane_q <= '0;
      lanes  <= '0;
    end else if (clr) begin
      lane_q <= '0;
      lanes  <= '0;
    end else if (wr) begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      lane_q <= assembled;
      lanes  <= lanes + lane_idx_t'(1);
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs PACK FIFO words into one wide valid/ready word; flush emits a partial word.
// Optional concurrent checks are compiled when FIFO_RD_PACKER_SVA_EN is defined.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PACK  = 4   // legal range 2..16
) (
  input logic              clk,
  input logic              res,
  fifo_rd_packer_if.master bus
);

  localparam int        CW   = $clog2(PACK + 1);
  localparam lane_idx_t FULL = lane_idx_t'(PACK);
  localparam lane_idx_t LAST = lane_idx_t'(PACK - 1);

  state_t                     state;
  logic                       inflight;
  lane_idx_t                  lanes;
  logic [PACK-1:0][WIDTH-1:0] assembled;
  logic                       out_free;
  logic                       last_cap;
  logic                       rd_en;
  logic                       load;
  lane_idx_t                  load_cnt;

  assign out_free = !bus.out_valid || bus.out_ready;
  assign last_cap = inflight && (lanes == LAST);
  // Counting the in-flight read keeps the assembler from being overrun; costs one bubble per word.
  assign rd_en    = res && (state == FILL) && !bus.fifo_empty &&
                    ((lanes + lane_idx_t'(inflight)) < FULL);
  assign bus.fifo_rd_en = rd_en;

  always_comb begin
    load     = 1'b0;
    load_cnt = FULL;
    unique case (state)
      FILL:  load = last_cap && out_free;
      STALL: load = out_free;
      FLUSH: begin
        load     = !inflight && out_free;
        load_cnt = lanes;
      end
      default: load = 1'b0;
    endcase
  end

  fifo_lane_asm #(
    .WIDTH(WIDTH),
    .PACK (PACK)
  ) u_lane_asm (
    .clk      (clk),
    .res      (res),
    .wr       (inflight),
    .wr_data  (bus.fifo_rdata),
    .clr      (load),
    .lanes    (lanes),
    .assembled(assembled)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state         <= FILL;
      inflight      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_cnt   <= '0;
      bus.err       <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (bus.fifo_underflow) bus.err <= 1'b1;

      if (load) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= assembled;
        bus.out_cnt   <= CW'(load_cnt);
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      unique case (state)
        FILL: begin
          // A completing capture wins over flush; the flushed word would be identical.
          if (last_cap && !out_free)
            state <= STALL;
          else if (!last_cap && bus.flush && ((lanes != '0) || inflight))
            state <= FLUSH;
        end
        STALL, FLUSH: if (load) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

`ifdef FIFO_RD_PACKER_SVA_EN
  a_no_rd_when_empty: assert property (@(posedge clk) disable iff (!res)
    bus.fifo_empty |-> !bus.fifo_rd_en);

  a_out_hold: assert property (@(posedge clk) disable iff (!res)
    (bus.out_valid && !bus.out_ready) |=> ($stable(bus.out_data) && $stable(bus.out_cnt)));

  a_cnt_nonzero: assert property (@(posedge clk) disable iff (!res)
    bus.out_valid |-> (bus.out_cnt != '0));

  a_reset_vals: assert property (@(posedge clk) disable iff (!res)
    $rose(res) |-> ##0 (!bus.out_valid && (bus.out_data == '0) && (bus.out_cnt == '0) &&
                        !bus.err && (state == FILL) && (lanes == '0) && !inflight));
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer (WIDTH=8, PACK=4) with a queue-based FIFO and packing reference.
module tb_fifo_rd_packer;

  localparam int WIDTH = 8;
  localparam int PACK  = 4;
  localparam int CW    = $clog2(PACK + 1);
  localparam int OW    = WIDTH * PACK;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic res;
  int   n_cmp = 0;
  int   n_err = 0;
  int   reads = 0;
  logic toggle_en;
  logic toggle_phase;

  logic [WIDTH-1:0] src_q[$];   // words the FIFO still holds
  logic [WIDTH-1:0] asm_q[$];   // words pushed but not yet grouped into an output word
  exp_t             exp_q[$];   // output words still owed by the DUT

  fifo_rd_packer_if #(.WIDTH(WIDTH), .PACK(PACK)) bus ();

  fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK)) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic void emit_model();
    exp_t e;
    e.data = '0;
    for (int i = 0; i < asm_q.size(); i++) e.data[i*WIDTH +: WIDTH] = asm_q[i];
    e.cnt = CW'(asm_q.size());
    exp_q.push_back(e);
    asm_q.delete();
  endfunction

  function automatic void push_word(input logic [WIDTH-1:0] w);
    src_q.push_back(w);
    asm_q.push_back(w);
    if (asm_q.size() == PACK) emit_model();
  endfunction

  function automatic void model_flush();
    if (asm_q.size() != 0) emit_model();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIFO read port with one-cycle latency plus output scoreboard.
  task automatic run_model();
    logic [WIDTH-1:0] w;
    logic             got;
    exp_t             e;
    w = '0;
    forever begin
      @(negedge clk);
      got = 1'b0;
      if (res === 1'b1) begin
        if (bus.fifo_empty) check("rd_en_while_empty", bus.fifo_rd_en, 64'd0);
        if (bus.fifo_rd_en && !bus.fifo_empty) begin
          w   = src_q.pop_front();
          got = 1'b1;
          reads++;
        end
        if (bus.out_valid && bus.out_ready) begin
          check("out_expected", exp_q.size() != 0, 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_cnt", bus.out_cnt, e.cnt);
          end
        end
      end
      @(posedge clk);
      #1;
      toggle_phase   = !toggle_phase;
      bus.fifo_rdata = got ? w : WIDTH'($urandom);
      bus.fifo_empty = (src_q.size() == 0) || (toggle_en && toggle_phase);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check(tag, exp_q.size() == 0, 64'd1);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    model_flush();
    tick();
    bus.flush = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    res                = 1'b0;
    bus.out_ready      = 1'b1;
    bus.flush          = 1'b0;
    bus.fifo_underflow = 1'b0;
    bus.fifo_empty     = 1'b1;
    bus.fifo_rdata     = '0;
    toggle_en          = 1'b0;
    toggle_phase       = 1'b0;
    fork
      run_model();
    join_none

    // Reset held with data available.
    for (int i = 1; i <= 8; i++) push_word(WIDTH'(8'h11 * i));
    repeat (3) tick();
    @(negedge clk);
    check("rst_rd_en", bus.fifo_rd_en, 64'd0);
    check("rst_out_valid", bus.out_valid, 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_cnt", bus.out_cnt, 64'd0);
    check("rst_err", bus.err, 64'd0);
    tick();
    res = 1'b1;
    @(negedge clk);
    check("first_rd_en", bus.fifo_rd_en, 64'd1);

    // Latency: first word valid in cycle 5, second in cycle 10.
    repeat (4) tick();
    @(negedge clk);
    check("c4_valid", bus.out_valid, 64'd0);
    tick();
    @(negedge clk);
    check("c5_valid", bus.out_valid, 64'd1);
    check("c5_data", bus.out_data, 64'h44332211);
    check("c5_cnt", bus.out_cnt, 64'd4);
    repeat (5) tick();
    @(negedge clk);
    check("c10_valid", bus.out_valid, 64'd1);
    check("c10_data", bus.out_data, 64'h88776655);

    // Back-pressure: two words assemble, then reads stop.
    tick();
    bus.out_ready = 1'b0;
    base = reads;
    for (int i = 0; i < 12; i++) push_word(WIDTH'($urandom));
    repeat (25) tick();
    @(negedge clk);
    check("stall_reads", reads - base, 64'd8);
    check("stall_rd_en", bus.fifo_rd_en, 64'd0);
    check("stall_valid", bus.out_valid, 64'd1);
    check("stall_hold", bus.out_data, exp_q[0].data);
    tick();
    bus.out_ready = 1'b1;
    wait_drain("stall_drain");
    check("stall_src_empty", src_q.size() == 0, 64'd1);

    // Flush of a three-word partial.
    repeat (2) tick();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    repeat (8) tick();
    pulse_flush();
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("flush_data", bus.out_data, 64'h00332211);
    check("flush_cnt", bus.out_cnt, 64'd3);
    wait_drain("flush_drain");

    // Random bursts, random ready, optional empty toggling and flushes.
    for (int it = 0; it < 40; it++) begin
      tick();
      toggle_en = it[0];
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) push_word(WIDTH'($urandom));
      n = 0;
      while (src_q.size() != 0 && n < 400) begin
        tick();
        bus.out_ready = ($urandom_range(0, 3) != 0);
        n++;
      end
      check("rand_src_drained", src_q.size() == 0, 64'd1);
      if ($urandom_range(0, 2) == 0) begin
        bus.out_ready = 1'b1;
        wait_drain("rand_pre_flush");
        repeat (2) tick();
        pulse_flush();
      end
    end
    toggle_en     = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("final_drain");
    repeat (2) tick();
    pulse_flush();
    wait_drain("final_flush");

    // Sticky error flag.
    @(negedge clk);
    check("err_before", bus.err, 64'd0);
    tick();
    bus.fifo_underflow = 1'b1;
    tick();
    bus.fifo_underflow = 1'b0;
    @(negedge clk);
    check("err_set", bus.err, 64'd1);
    repeat (6) tick();
    @(negedge clk);
    check("err_sticky", bus.err, 64'd1);
    res = 1'b0;
    #1;
    check("err_cleared", bus.err, 64'd0);
    check("rst2_out_valid", bus.out_valid, 64'd0);
    check("rst2_rd_en", bus.fifo_rd_en, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
